afe_tx_sched: RTL
=================

AFE_TX_SCHED -- requirements
Module: afe_tx_sched

Interface
REQ-001 SHALL have parameter IQ_PAIR_WIDTH, default 24, width of one packed I/Q pair.
REQ-002 SHALL have parameter WARMUP_CYCLES, default 8, zero-pair cycles after tx_en rises and before first data.
REQ-003 SHALL have parameter TAIL_CYCLES, default 4, zero-pair cycles after last data and before tx_en falls.
REQ-004 SHALL have parameter MAX_BURST, default 256, maximum pairs served from one source per grant.
REQ-005 tx_fifo_clk  in  1  pair-rate clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  master TX enable.
REQ-008 loopback  in  1  1 = source B has strict priority; 0 = round-robin A/B.
REQ-009 a_empty / b_empty  in  1  source FIFO empty, first-word-fall-through.
REQ-010 a_data / b_data  in  IQ_PAIR_WIDTH  head-of-FIFO pair, valid when corresponding empty=0.
REQ-011 a_rd / b_rd  out  1  pop strobe, combinational from state and empty.
REQ-012 pair_data  out  IQ_PAIR_WIDTH  registered pair to AFE TX serializer.
REQ-013 pair_valid  out  1  registered; pair_data is meaningful.
REQ-014 tx_en  out  1  registered AFE transmit enable.
REQ-015 src_sel  out  1  registered; source of current/last burst, 0=A, 1=B.
REQ-016 underrun_cnt  out  16  saturating count of bursts ended by empty source.
REQ-017 busy  out  1  1 in any state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, WARMUP, STREAM, TAIL.
REQ-019 IDLE: tx_en=0, pair_valid=0, pair_data=0, no rd; go to WARMUP when enable=1 and an eligible source is non-empty; grant chosen per REQ-023.
REQ-020 WARMUP: tx_en=1, pair_valid=1, pair_data=0 for exactly WARMUP_CYCLES cycles, then STREAM; enable falling in WARMUP -> TAIL.
REQ-021 STREAM: when granted source non-empty and enable=1, assert its rd that cycle; next cycle pair_data=popped word, pair_valid=1 (latency 1); burst counter +1.
REQ-022 Burst SHALL end on: counter reaching MAX_BURST, granted source empty, or enable=0; no rd in the ending cycle unless it is the MAX_BURST-th pop.
REQ-023 Arbitration at grant/burst end: loopback=1 -> B if non-empty else A; loopback=0 -> the source not served last if non-empty, else the other; initial last-served = B (A wins first tie).
REQ-024 At burst end with enable=1 and a source non-empty, new grant SHALL take effect next cycle in STREAM with no gap and no re-warmup; src_sel updates with the first pair of the new burst.
REQ-025 At burst end with no non-empty source, or enable=0 -> TAIL.
REQ-026 Burst ended by empty source (count < MAX_BURST, enable=1) SHALL increment underrun_cnt, saturating at 0xFFFF; a cycle with no pop SHALL drive pair_data=0, pair_valid=1 while tx_en=1.
REQ-027 TAIL: tx_en=1, pair_valid=1, pair_data=0 for exactly TAIL_CYCLES cycles, then IDLE; new data during TAIL SHALL NOT abort TAIL.
REQ-028 a_rd and b_rd SHALL never both be 1, and SHALL never be 1 while corresponding empty=1.
REQ-029 Simultaneous source going non-empty and MAX_BURST reached: arbitration per REQ-023 using empty values of that cycle.
REQ-030 Burst counter and WARMUP/TAIL counters SHALL reset to 0 on each state entry.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, tx_en=0, pair_valid=0, pair_data=0, src_sel=0, busy=0, underrun_cnt=0, last-served=B, all counters 0; a_rd=b_rd=0 while reset_n low.
REQ-032 Reset mid-burst SHALL drop pending words without pop; after release the first new pop occurs no earlier than WARMUP_CYCLES+1 cycles after leaving IDLE.

Verification
REQ-033 enable=1, loopback=0, A holds 3 pairs, B empty -> tx_en rises, 8 zero pairs, 3 A pairs in order, underrun_cnt=1, 4 zero pairs, tx_en falls, busy=0.
REQ-034 loopback=0, A and B each hold 600 pairs, MAX_BURST=256 -> bursts A256,B256,A256,B256,A88,B88 with no gaps; underrun_cnt=2 (A then B ending empty).
REQ-035 loopback=1, A and B both non-empty -> only b_rd pulses until B empties, then A served without re-warmup.
REQ-036 enable dropped at pair 10 of a burst -> no further rd, 4 zero pairs, tx_en=0, underrun_cnt unchanged.
REQ-037 reset_n pulsed low mid-STREAM -> all outputs 0 same cycle, no rd; on release with data present, WARMUP restarts from 0.
REQ-038 Force 65540 empty-ended bursts -> underrun_cnt holds 0xFFFF.

Source files
------------

// File: rtl/afe_tx_sched.sv
// AFE transmit scheduler: arbitrates two FWFT I/Q sources into bursts framed by
// zero-pair warm-up and tail periods, with a registered pair stream to the serializer.
module afe_tx_sched #(
    parameter int IQ_PAIR_WIDTH = 24,
    parameter int WARMUP_CYCLES = 8,
    parameter int TAIL_CYCLES   = 4,
    parameter int MAX_BURST     = 256
) (
    input  logic                     tx_fifo_clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     loopback,
    input  logic                     a_empty,
    input  logic                     b_empty,
    input  logic [IQ_PAIR_WIDTH-1:0] a_data,
    input  logic [IQ_PAIR_WIDTH-1:0] b_data,
    output logic                     a_rd,
    output logic                     b_rd,
    output logic [IQ_PAIR_WIDTH-1:0] pair_data,
    output logic                     pair_valid,
    output logic                     tx_en,
    output logic                     src_sel,
    output logic [15:0]              underrun_cnt,
    output logic                     busy
);

    localparam int PHASE_MAX = (WARMUP_CYCLES > TAIL_CYCLES) ? WARMUP_CYCLES : TAIL_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int BW        = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, WARMUP, STREAM, TAIL} state_t;

    state_t                   r_state, w_state_nxt;
    logic                     r_grant, w_grant_nxt;   // 1 = B; doubles as last-served
    logic [BW-1:0]            r_burst_cnt, w_burst_cnt_nxt;
    logic [PW-1:0]            r_phase_cnt, w_phase_cnt_nxt;
    logic [IQ_PAIR_WIDTH-1:0] r_pair_data;
    logic                     r_pair_valid;
    logic                     r_tx_en;
    logic                     r_src_sel;
    logic [15:0]              r_underrun_cnt;

    logic w_a_ne, w_b_ne, w_any_ne, w_gnt_ne;
    logic w_pop, w_last_pop, w_burst_end, w_underrun, w_arb;

    function automatic logic arbitrate(input logic lb, input logic a_ne,
                                       input logic b_ne, input logic last_b);
        if (lb) return b_ne;
        return last_b ? !a_ne : b_ne;
    endfunction

    assign w_a_ne      = !a_empty;
    assign w_b_ne      = !b_empty;
    assign w_any_ne    = w_a_ne | w_b_ne;
    assign w_gnt_ne    = r_grant ? w_b_ne : w_a_ne;
    assign w_pop       = (r_state == STREAM) && enable && w_gnt_ne;
    assign w_last_pop  = w_pop && (r_burst_cnt == BW'(MAX_BURST - 1));
    assign w_burst_end = (r_state == STREAM) && (!w_pop || w_last_pop);
    assign w_underrun  = w_burst_end && enable && !w_gnt_ne;
    // Arbitration sees this cycle's flags, so a source on its MAX_BURST-th pop still counts as non-empty.
    assign w_arb       = arbitrate(loopback, w_a_ne, w_b_ne, r_grant);

    assign a_rd = w_pop && !r_grant;
    assign b_rd = w_pop &&  r_grant;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_burst_cnt_nxt = r_burst_cnt;
        w_phase_cnt_nxt = r_phase_cnt;
        case (r_state)
            IDLE: begin
                if (enable && w_any_ne) begin
                    w_state_nxt     = WARMUP;
                    w_grant_nxt     = w_arb;
                    w_phase_cnt_nxt = '0;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    w_state_nxt     = TAIL;
                    w_phase_cnt_nxt = '0;
                end else if (r_phase_cnt == PW'(WARMUP_CYCLES - 1)) begin
                    w_state_nxt     = STREAM;
                    w_phase_cnt_nxt = '0;
                    w_burst_cnt_nxt = '0;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt + 1'b1;
                end
            end
            STREAM: begin
                if (w_burst_end) begin
                    w_burst_cnt_nxt = '0;
                    if (enable && w_any_ne) begin
                        w_grant_nxt = w_arb;
                    end else begin
                        w_state_nxt     = TAIL;
                        w_phase_cnt_nxt = '0;
                    end
                end else if (w_pop) begin
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            TAIL: begin
                if (r_phase_cnt == PW'(TAIL_CYCLES - 1)) begin
                    w_state_nxt     = IDLE;
                    w_phase_cnt_nxt = '0;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs trail the state by one cycle: a pop in cycle t is presented in cycle t+1.
    always_ff @(posedge tx_fifo_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_grant        <= 1'b1;
            r_burst_cnt    <= '0;
            r_phase_cnt    <= '0;
            r_pair_data    <= '0;
            r_pair_valid   <= 1'b0;
            r_tx_en        <= 1'b0;
            r_src_sel      <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_phase_cnt  <= w_phase_cnt_nxt;
            r_tx_en      <= (r_state != IDLE);
            r_pair_valid <= (r_state != IDLE);
            r_pair_data  <= w_pop ? (r_grant ? b_data : a_data) : '0;
            if (w_pop) r_src_sel <= r_grant;
            if (w_underrun && (r_underrun_cnt != 16'hFFFF))
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign pair_data    = r_pair_data;
    assign pair_valid   = r_pair_valid;
    assign tx_en        = r_tx_en;
    assign src_sel      = r_src_sel;
    assign underrun_cnt = r_underrun_cnt;
    assign busy         = (r_state != IDLE);

endmodule
